// File: rtl/cell_test_pkg.sv
// Shared types and constants for the standard-cell test board.
// No logic of its own; holds the exerciser FSM states and per-cell truth tables.
// Truth tables are indexed by the stimulus vector: bit i is the expected Y for stim==i.
package cell_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // OAI21: Y = ~(A & (B1 | B2)), stim = {A, B1, B2}
    localparam logic [7:0] OAI21_TT = 8'h1F;
    // AOI21: Y = ~((A1 & A2) | B), stim = {A1, A2, B}
    localparam logic [7:0] AOI21_TT = 8'h15;
    // NAND3: Y = ~(A & B & C), stim = {A, B, C}
    localparam logic [7:0] NAND3_TT = 8'h7F;
    // NOR3: Y = ~(A | B | C), stim = {A, B, C}
    localparam logic [7:0] NOR3_TT  = 8'h01;
    // NAND2: Y = ~(A & B), stim = {A, B}
    localparam logic [3:0] NAND2_TT = 4'h7;
    // NOR2: Y = ~(A | B), stim = {A, B}
    localparam logic [3:0] NOR2_TT  = 4'h1;
    // INV: Y = ~A, stim = {A}
    localparam logic [1:0] INV_TT   = 2'h1;

endpackage

// File: rtl/cell_exerciser_sync2.sv
// Two-flop synchronizer for a single asynchronous level (cell output into the clk domain).
// Latency: 2 clk cycles from a stable input to q.
// No backpressure; samples every cycle, reset drives both stages to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // First stage may go metastable; second stage gives it a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/cell_exerciser.sv
// Sweeps every input vector into a combinational cell and checks Y against a truth table.
// Latency: SETTLE+3 cycles per vector, 2**N_IN*(SETTLE+3)+1 cycles from start to done.
// No backpressure; start is a pulse and is ignored while a sweep is in progress.
module cell_exerciser
    import cell_test_pkg::*;
#(
    parameter int                   N_IN   = 3,
    parameter logic [2**N_IN-1:0]   TRUTH  = OAI21_TT,
    parameter int                   SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dut_y,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   fail_vec
);

    // The hold counter covers the settle time plus the synchronizer depth,
    // so the sampled Y belongs to the vector currently on stim.
    localparam int                 CNT_W    = $clog2(SETTLE + 2);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE + 1);
    localparam logic [N_IN-1:0]    LAST_VEC = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_IN-1:0]     r_stim;
    logic [N_IN-1:0]     w_stim_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ERR_W-1:0]    r_err;
    logic [ERR_W-1:0]    w_err_nxt;
    logic [N_IN-1:0]     r_fail_vec;
    logic [N_IN-1:0]     w_fail_nxt;

    logic                w_y;
    logic                w_mismatch;

    // dut_y is asynchronous to clk; it is only ever used after this synchronizer.
    sync2 u_sync_y (
        .clk (clk),
        .rst (rst),
        .d   (dut_y),
        .q   (w_y)
    );

    assign w_mismatch = (w_y != TRUTH[r_stim]);

    // State and datapath registers; async reset discards any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stim     <= '0;
            r_cnt      <= '0;
            r_err      <= '0;
            r_fail_vec <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_stim     <= w_stim_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_fail_vec <= w_fail_nxt;
        end
    end

    // Next-state and datapath updates: hold each vector, sample once, step or finish.
    always_comb begin
        w_state_nxt = r_state;
        w_stim_nxt  = r_stim;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail_vec;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                // DONE keeps its results and last vector until a new sweep is requested.
                if (start) begin
                    w_state_nxt = ST_APPLY;
                    w_stim_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = '0;
                end
            end

            ST_APPLY: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (w_mismatch) begin
                    if (r_err == '0) begin
                        w_fail_nxt = r_stim;
                    end
                    if (r_err != ERR_MAX) begin
                        w_err_nxt = r_err + 1'b1;
                    end
                end
                // The last vector ends the sweep, so stim never wraps mid-sweep.
                if (r_stim == LAST_VEC) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_stim_nxt  = r_stim + 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_APPLY;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status flags are decoded from registered state only, never from dut_y directly.
    assign stim      = r_stim;
    assign busy      = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign done      = (r_state == ST_DONE);
    assign pass      = (r_state == ST_DONE) && (r_err == '0);
    assign err_count = r_err;
    assign fail_vec  = r_fail_vec;

endmodule
